mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between the Fetch stage (instruction reads) and the Memory stage (loads and stores) of the pipelined RISC-V core.
- Grants one requester at a time and holds a level handshake with the memory until it acknowledges.
- Returns read data and a one-cycle done pulse to the granted requester.
- Drives the stall signals that the hazard unit ORs into StallF/StallD and StallE/StallM.

Parameters:
- AW, 32, address width
- DW, 32, data width
- MAX_WAIT, 4, number of cycles Fetch may be kept waiting while Data is granted before Fetch is forced to win (range 1..15)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  Fetch requests an instruction read; held until if_done
- if_addr  in  AW  fetch address (PCF); stable while if_req is high
- if_rdata  out  DW  instruction word; valid only when if_done=1
- if_done  out  1  one-cycle pulse: fetch complete
- if_stall  out  1  Fetch stage must hold
- dm_req  in  1  Memory stage requests an access; held until dm_done
- dm_we  in  1  1=store, 0=load; stable while dm_req is high
- dm_addr  in  AW  data address (ALUResultM)
- dm_wdata  in  DW  store data (WriteDataM)
- dm_rdata  out  DW  load data; valid only when dm_done=1
- dm_done  out  1  one-cycle pulse: data access complete
- dm_stall  out  1  Memory stage and everything upstream of it must hold
- mem_req  out  1  request to memory; level signal, held until mem_ack
- mem_we  out  1  write enable to memory
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_ack  in  1  memory completes the access this cycle
- mem_rdata  in  DW  read data; valid with mem_ack

Behaviour:
- Clock and reset: one clock domain (clk). reset is asynchronous and active-high.
- Reset values:
  - state = IDLE, starve count = 0
  - mem_req, mem_we, if_done, dm_done = 0
  - mem_addr, mem_wdata, if_rdata, dm_rdata = 0
- FSM states: IDLE, BUSY_IF, BUSY_DM.
- Eligibility in IDLE: a requester is eligible if its req=1 and its done output is 0 in the current cycle. A done pulse means the pipeline advances on that edge, so the held request is stale.
- IDLE arbitration, evaluated in this order:
  - Both eligible and count == MAX_WAIT: go to BUSY_IF.
  - Both eligible otherwise: go to BUSY_DM (data has priority).
  - Only one eligible: go to that requester's BUSY state.
  - Neither eligible: stay in IDLE.
- On entering BUSY_x, the arbiter registers mem_req=1 and captures mem_addr, mem_we and mem_wdata from requester x. For Fetch, mem_we=0 and mem_wdata=0. These values stay stable for the whole BUSY state.
- In BUSY_x with mem_ack=0: stay in BUSY_x and keep mem_req=1.
- In BUSY_x with mem_ack=1:
  - Next state is IDLE and mem_req goes to 0 on that edge.
  - x_rdata is registered from mem_rdata (stores register it as well, and the value is ignored).
  - x_done = 1 for exactly the next cycle.
- Latency: minimum is 3 cycles from request to done (req seen in IDLE → BUSY with mem_ack in the first BUSY cycle → done). This is one extra cycle per mem_ack cycle waited.
- Back-to-back requests: there is always one IDLE cycle between grants. That IDLE cycle is the done cycle.
- Starvation counter:
  - Increments, saturating at MAX_WAIT, on each cycle that state == BUSY_DM and if_req == 1.
  - Clears when BUSY_IF is entered.
  - Otherwise holds.
- Stalls (combinational):
  - if_stall = if_req & ~if_done
  - dm_stall = dm_req & ~dm_done
- mem_ack in IDLE is ignored: no state change, no done pulse.
- Reset mid-access: an asynchronous return to IDLE. A pending mem_ack is dropped and no done is generated. Memory must tolerate mem_req being withdrawn.
- The arbiter never sees a requester drop req mid-BUSY (this is a protocol rule for requesters). If it happens, the access still completes and done still pulses.

Decomposition:
- Package mem_arb_pkg:
  - enum arb_state_t {IDLE, BUSY_IF, BUSY_DM}
  - enum grant_t {GNT_IF, GNT_DM}
  - localparam for the default MAX_WAIT
- Sub-module arb_starve_counter: saturating counter with increment, clear and max-compare output (at_max). It is instantiated once.

Test Plan:
- Fetch only: if_req=1, if_addr=0x10, mem_ack on the 1st BUSY cycle with rdata=0x00500113 → mem_req high for 1 cycle with addr=0x10; if_done at cycle 3 with if_rdata=0x00500113; if_stall high in cycles 1–2.
- Simultaneous requests: if_req and dm_req both 1, dm_we=1, addr=0x80, wdata=0xDEADBEEF, mem_ack after 2 cycles → store granted first with mem_we=1; dm_done pulses; Fetch is then granted after one IDLE cycle.
- Starvation: MAX_WAIT=4, if_req held high, and a new dm_req presented immediately after every dm_done → Fetch wins once count reaches 4; count clears to 0 when BUSY_IF is entered.
- Wait states: load at 0x40 with mem_ack delayed 5 cycles → mem_req and mem_addr stable for all 5 cycles; dm_done appears exactly 1 cycle after mem_ack.
- Reset mid-BUSY_DM: assert reset for 1 cycle before mem_ack, then give a stray mem_ack → all outputs return to reset values immediately; no dm_done; the FSM stays in IDLE.
- Spurious ack: mem_ack=1 while IDLE with no requests → no done pulse, mem_req stays 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified instruction/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_DM
    } arb_state_t;

    typedef enum logic {
        GNT_IF,
        GNT_DM
    } grant_t;

    localparam int DEFAULT_MAX_WAIT = 4;
    localparam int STARVE_CNT_W     = 4;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of cycles Fetch has waited behind a Data access.
module arb_starve_counter
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam logic [STARVE_CNT_W-1:0] MAX_CNT = STARVE_CNT_W'(MAX_WAIT);

    logic [STARVE_CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != MAX_CNT)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign at_max = (count_q == MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between Fetch and the Memory stage,
// holding a level req/ack handshake and returning data with a one-cycle done pulse.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    output logic          if_stall,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_done,
    output logic          dm_stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_t    state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic          if_done_q, if_done_d;
    logic          dm_done_q, dm_done_d;

    logic   if_elig, dm_elig, grant_valid, at_max;
    grant_t grant;

    // A requester whose done is pulsing is about to advance, so its held req is stale.
    always_comb begin
        if_elig     = if_req & ~if_done_q;
        dm_elig     = dm_req & ~dm_done_q;
        grant_valid = 1'b0;
        grant       = GNT_DM;
        if (if_elig && dm_elig) begin
            grant_valid = 1'b1;
            grant       = at_max ? GNT_IF : GNT_DM;
        end else if (dm_elig) begin
            grant_valid = 1'b1;
            grant       = GNT_DM;
        end else if (if_elig) begin
            grant_valid = 1'b1;
            grant       = GNT_IF;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_done_d   = 1'b0;
        dm_done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    mem_req_d = 1'b1;
                    if (grant == GNT_IF) begin
                        state_d     = BUSY_IF;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                    end else begin
                        state_d     = BUSY_DM;
                        mem_we_d    = dm_we;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                    end
                end
            end
            BUSY_IF: begin
                if (mem_ack) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    if_rdata_d = mem_rdata;
                    if_done_d  = 1'b1;
                end
            end
            BUSY_DM: begin
                if (mem_ack) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    dm_rdata_d = mem_rdata;
                    dm_done_d  = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_done_q   <= if_done_d;
            dm_done_q   <= dm_done_d;
        end
    end

    arb_starve_counter #(
        .MAX_WAIT(MAX_WAIT)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .inc   ((state_q == BUSY_DM) && if_req),
        .clr   ((state_q == IDLE) && grant_valid && (grant == GNT_IF)),
        .at_max(at_max)
    );

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_done   = if_done_q;
    assign dm_done   = dm_done_q;
    assign if_stall  = if_req & ~if_done_q;
    assign dm_stall  = dm_req & ~dm_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requesters push expected done events,
// a negedge monitor matches every done pulse against them.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        if_stall;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic        dm_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        bit          is_dm;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   mon_idx;

    mem_port_arbiter #(
        .AW(32),
        .DW(32),
        .MAX_WAIT(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_done  (if_done),
        .if_stall (if_stall),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_done  (dm_done),
        .dm_stall (dm_stall),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match an outstanding expectation for that port.
    always @(negedge clk) begin
        if (if_done === 1'b1 || dm_done === 1'b1) begin
            checkOutput("done_exclusive", {31'b0, if_done & dm_done}, 32'd0);
            mon_idx = -1;
            for (int i = 0; i < exp_q.size(); i++) begin
                if (mon_idx < 0 && exp_q[i].is_dm == dm_done) mon_idx = i;
            end
            if (mon_idx < 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: if_done=%0b dm_done=%0b with no pending request (cycle %0d)",
                         if_done, dm_done, cyc);
            end else begin
                mon_e = exp_q[mon_idx];
                exp_q.delete(mon_idx);
                checkOutput(mon_e.is_dm ? "dm_rdata" : "if_rdata",
                            mon_e.is_dm ? dm_rdata : if_rdata, mon_e.rdata);
                checkOutput(mon_e.is_dm ? "dm_done_cycle" : "if_done_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Requester: holds req through its done cycle, then drops it.
    task automatic applyStimulus(input bit is_dm, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] exp_rdata, input int lat);
        int exp_cyc;
        bit seen;
        exp_cyc = cyc + lat;
        if (is_dm) begin
            dm_req   = 1'b1;
            dm_we    = we;
            dm_addr  = addr;
            dm_wdata = wdata;
        end else begin
            if_req  = 1'b1;
            if_addr = addr;
        end
        exp_q.push_back('{is_dm, exp_rdata, exp_cyc});
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            checkOutput(is_dm ? "dm_stall" : "if_stall",
                        {31'b0, is_dm ? dm_stall : if_stall}, {31'b0, cyc != exp_cyc});
            seen = is_dm ? dm_done : if_done;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: is_dm=%0b got no done, expected at cycle %0d", is_dm, exp_cyc);
        end
        @(posedge clk);
        #1;
        if (is_dm) dm_req = 1'b0;
        else if_req = 1'b0;
    endtask

    // Memory model: waits for a grant, checks the request is stable, acks after 'delay' cycles.
    task automatic memServe(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                            input int delay, input logic [31:0] rdata);
        int n;
        n = 0;
        while (mem_req !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("[TB] FAIL mem_req_timeout: got mem_req=%0b expected 1 for addr 0x%08h", mem_req, addr);
            return;
        end
        for (int i = 0; i <= delay; i++) begin
            if (i == delay) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
            end
            @(negedge clk);
            checkOutput("mem_req", {31'b0, mem_req}, 32'd1);
            checkOutput("mem_addr", mem_addr, addr);
            checkOutput("mem_we", {31'b0, mem_we}, {31'b0, we});
            checkOutput("mem_wdata", mem_wdata, wdata);
            @(posedge clk);
            #1;
        end
        mem_ack   = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_mem_req"}, {31'b0, mem_req}, 32'd0);
        checkOutput({tag, "_mem_we"}, {31'b0, mem_we}, 32'd0);
        checkOutput({tag, "_mem_addr"}, mem_addr, 32'd0);
        checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        checkOutput({tag, "_if_rdata"}, if_rdata, 32'd0);
        checkOutput({tag, "_dm_rdata"}, dm_rdata, 32'd0);
        checkOutput({tag, "_dones"}, {30'b0, if_done, dm_done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got cycle %0d expected under 20000", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        #1;
        checkResetValues("reset");
        idle(2);
        reset = 1'b0;
        idle(2);

        $display("[TB] fetch only");
        fork
            applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, 32'h0050_0113, 2);
            memServe(32'h10, 1'b0, 32'h0, 0, 32'h0050_0113);
        join
        @(negedge clk);
        checkOutput("no_regrant_after_if_done", {31'b0, mem_req}, 32'd0);
        idle(2);

        $display("[TB] simultaneous store and fetch");
        fork
            applyStimulus(1'b1, 1'b1, 32'h80, 32'hDEAD_BEEF, 32'h1111_1111, 4);
            applyStimulus(1'b0, 1'b0, 32'h14, 32'h0, 32'h00A0_0193, 6);
            begin
                memServe(32'h80, 1'b1, 32'hDEAD_BEEF, 2, 32'h1111_1111);
                memServe(32'h14, 1'b0, 32'h0, 0, 32'h00A0_0193);
            end
        join
        idle(2);

        $display("[TB] wait states on a load");
        fork
            applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 32'hCAFE_F00D, 7);
            memServe(32'h40, 1'b0, 32'h0, 5, 32'hCAFE_F00D);
        join
        @(negedge clk);
        checkOutput("no_regrant_after_dm_done", {31'b0, mem_req}, 32'd0);
        idle(2);

        $display("[TB] fetch waits behind a long load, then is served");
        fork
            applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 32'h0000_0001, 7);
            begin
                idle(1);
                applyStimulus(1'b0, 1'b0, 32'h20, 32'h0, 32'h0000_0013, 8);
            end
            begin
                memServe(32'h100, 1'b0, 32'h0, 5, 32'h0000_0001);
                memServe(32'h20, 1'b0, 32'h0, 0, 32'h0000_0013);
            end
        join
        idle(2);

        $display("[TB] counter cleared: simultaneous requests go to data first");
        fork
            applyStimulus(1'b1, 1'b0, 32'h44, 32'h0, 32'h0000_0AAA, 2);
            applyStimulus(1'b0, 1'b0, 32'h28, 32'h0, 32'h0000_0BBB, 4);
            begin
                memServe(32'h44, 1'b0, 32'h0, 0, 32'h0000_0AAA);
                memServe(32'h28, 1'b0, 32'h0, 0, 32'h0000_0BBB);
            end
        join
        idle(2);

        $display("[TB] starvation count reaches the limit without fetch being served");
        fork
            applyStimulus(1'b1, 1'b0, 32'h104, 32'h0, 32'h0000_0002, 7);
            begin
                idle(1);
                if_req  = 1'b1;
                if_addr = 32'h30;
                idle(4);
                if_req  = 1'b0;
            end
            memServe(32'h104, 1'b0, 32'h0, 5, 32'h0000_0002);
        join
        idle(2);

        $display("[TB] at the limit fetch wins a simultaneous request");
        fork
            applyStimulus(1'b0, 1'b0, 32'h24, 32'h0, 32'h0000_0093, 2);
            applyStimulus(1'b1, 1'b1, 32'h108, 32'h0BAD_CAFE, 32'h55AA_55AA, 4);
            begin
                memServe(32'h24, 1'b0, 32'h0, 0, 32'h0000_0093);
                memServe(32'h108, 1'b1, 32'h0BAD_CAFE, 0, 32'h55AA_55AA);
            end
        join
        idle(2);

        $display("[TB] reset in the middle of a data access");
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 32'h200;
        dm_wdata = 32'h1234_5678;
        idle(1);
        checkOutput("rst_pre_mem_req", {31'b0, mem_req}, 32'd1);
        checkOutput("rst_pre_mem_addr", mem_addr, 32'h200);
        idle(1);
        reset = 1'b1;
        #1;
        checkResetValues("mid_reset");
        idle(1);
        reset     = 1'b0;
        dm_req    = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        idle(1);
        mem_ack   = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("post_reset_mem_req", {31'b0, mem_req}, 32'd0);
        end
        checkOutput("post_reset_dm_rdata", dm_rdata, 32'd0);
        idle(1);

        $display("[TB] spurious ack while idle");
        mem_ack   = 1'b1;
        mem_rdata = 32'h7777_7777;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("spurious_mem_req", {31'b0, mem_req}, 32'd0);
        end
        idle(1);
        mem_ack   = 1'b0;
        mem_rdata = '0;
        idle(2);
        checkResetValues("after_spurious");

        checkOutput("scoreboard_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
